// File: rtl/ysyx_20020207_lsu_pkg.sv
// Shared constants and types for the ysyx_20020207 load/store unit.
package ysyx_20020207_lsu_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned HALF_W    = 16;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_LANES = WORD_W / BYTE_W;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/ysyx_20020207_lsu_align.sv
// Byte-lane steering for stores and shift/extend for loads.
// The misaligned_o port exists only when LSU_MISALIGN_CHECK_EN is defined.
module ysyx_20020207_lsu_align
    import ysyx_20020207_lsu_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic [WORD_W-1:0] store_data_i,
    input  logic [WORD_W-1:0] rdata_i,
    output logic [3:0]        wstrb_o,
    output logic [WORD_W-1:0] wdata_o,
    output logic [WORD_W-1:0] load_data_o
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic              misaligned_o
`endif
);

    logic [WORD_W-1:0] shifted;

    always_comb begin
        wstrb_o = STRB_W;
        wdata_o = store_data_i;
        case (funct3_i)
            F3_SB: begin
                wstrb_o = 4'(STRB_B << offset_i);
                wdata_o = {NUM_LANES{store_data_i[BYTE_W-1:0]}};
            end
            F3_SH: begin
                wstrb_o = 4'(STRB_H << offset_i);
                wdata_o = {2{store_data_i[HALF_W-1:0]}};
            end
            default: begin
                wstrb_o = STRB_W;
                wdata_o = store_data_i;
            end
        endcase
    end

    // Selected byte/half is brought down to lane 0 before extension.
    always_comb begin
        shifted     = rdata_i >> {offset_i, 3'b000};
        load_data_o = shifted;
        case (funct3_i)
            F3_LB:   load_data_o = {{(WORD_W-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
            F3_LH:   load_data_o = {{(WORD_W-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
            F3_LBU:  load_data_o = {{(WORD_W-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
            F3_LHU:  load_data_o = {{(WORD_W-HALF_W){1'b0}}, shifted[HALF_W-1:0]};
            F3_LW:   load_data_o = shifted;
            default: load_data_o = shifted;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        case (funct3_i[1:0])
            2'b01:   misaligned_o = (offset_i == 2'd3);
            2'b10:   misaligned_o = (offset_i != 2'd0);
            default: misaligned_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/ysyx_20020207_lsu.sv
// Load/store unit: one bus transaction per memory instruction, pass-through otherwise.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module ysyx_20020207_lsu
    import ysyx_20020207_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [2:0]        funct3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              misalign,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wen,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rdata
);

    lsu_state_e        state_q, state_d;
    logic              kill_q, kill_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        offset_q, offset_d;
    logic              ren_q, ren_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              misalign_q, misalign_d;
    logic              bus_req_valid_q, bus_req_valid_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_wen_q, bus_wen_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;

    logic              accept_c;
    logic              mem_op_c;
    logic              bad_c;
    logic              idle_c;
    logic [2:0]        f3_sel_c;
    logic [1:0]        off_sel_c;
    logic [3:0]        wstrb_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] load_data_c;

    assign idle_c    = (state_q == S_IDLE);
    assign accept_c  = idle_c && in_valid && !flush;
    assign mem_op_c  = mem_ren || mem_wen;
    // Align unit sees live inputs while accepting, captured fields afterwards.
    assign f3_sel_c  = idle_c ? funct3 : funct3_q;
    assign off_sel_c = idle_c ? alu_result[1:0] : offset_q;

`ifdef LSU_MISALIGN_CHECK_EN
    logic misaligned_c;

    ysyx_20020207_lsu_align u_align (
        .funct3_i     (f3_sel_c),
        .offset_i     (off_sel_c),
        .store_data_i (store_data),
        .rdata_i      (bus_rdata),
        .wstrb_o      (wstrb_c),
        .wdata_o      (wdata_c),
        .load_data_o  (load_data_c),
        .misaligned_o (misaligned_c)
    );

    assign bad_c    = mem_op_c && misaligned_c;
    assign misalign = misalign_q;
`else
    ysyx_20020207_lsu_align u_align (
        .funct3_i     (f3_sel_c),
        .offset_i     (off_sel_c),
        .store_data_i (store_data),
        .rdata_i      (bus_rdata),
        .wstrb_o      (wstrb_c),
        .wdata_o      (wdata_c),
        .load_data_o  (load_data_c)
    );

    assign bad_c    = 1'b0;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            kill_q          <= 1'b0;
            funct3_q        <= 3'b000;
            offset_q        <= 2'b00;
            ren_q           <= 1'b0;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            result_q        <= '0;
            misalign_q      <= 1'b0;
            bus_req_valid_q <= 1'b0;
            bus_addr_q      <= '0;
            bus_wen_q       <= 1'b0;
            bus_wdata_q     <= '0;
            bus_wstrb_q     <= 4'b0000;
        end else begin
            state_q         <= state_d;
            kill_q          <= kill_d;
            funct3_q        <= funct3_d;
            offset_q        <= offset_d;
            ren_q           <= ren_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            result_q        <= result_d;
            misalign_q      <= misalign_d;
            bus_req_valid_q <= bus_req_valid_d;
            bus_addr_q      <= bus_addr_d;
            bus_wen_q       <= bus_wen_d;
            bus_wdata_q     <= bus_wdata_d;
            bus_wstrb_q     <= bus_wstrb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_c) state_d = (mem_op_c && !bad_c) ? S_REQ : S_DONE;
            S_REQ:  if (bus_req_ready) state_d = S_WAIT;
            // Killed transactions still drain the response, then skip write-back.
            S_WAIT: if (bus_rsp_valid) state_d = (kill_q || flush) ? S_IDLE : S_DONE;
            S_DONE: if (flush || out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        kill_d          = kill_q;
        funct3_d        = funct3_q;
        offset_d        = offset_q;
        ren_d           = ren_q;
        in_ready_d      = in_ready_q;
        out_valid_d     = out_valid_q;
        result_d        = result_q;
        misalign_d      = misalign_q;
        bus_req_valid_d = bus_req_valid_q;
        bus_addr_d      = bus_addr_q;
        bus_wen_d       = bus_wen_q;
        bus_wdata_d     = bus_wdata_q;
        bus_wstrb_d     = bus_wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    in_ready_d = 1'b0;
                    funct3_d   = funct3;
                    offset_d   = alu_result[1:0];
                    ren_d      = mem_ren;
                    misalign_d = bad_c;
                    kill_d     = 1'b0;
                    if (mem_op_c && !bad_c) begin
                        bus_req_valid_d = 1'b1;
                        bus_addr_d      = {alu_result[ADDR_W-1:2], 2'b00};
                        bus_wen_d       = mem_wen;
                        bus_wdata_d     = mem_wen ? wdata_c : '0;
                        bus_wstrb_d     = mem_wen ? wstrb_c : 4'b0000;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = DATA_W'(alu_result);
                    end
                end
            end
            S_REQ: begin
                kill_d = kill_q || flush;
                if (bus_req_ready) bus_req_valid_d = 1'b0;
            end
            S_WAIT: begin
                kill_d = kill_q || flush;
                if (bus_rsp_valid) begin
                    kill_d = 1'b0;
                    if (kill_q || flush) begin
                        in_ready_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = ren_q ? load_data_c : '0;
                    end
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign bus_req_valid = bus_req_valid_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wen       = bus_wen_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_wstrb     = bus_wstrb_q;

endmodule

// File: tb/tb_ysyx_20020207_lsu.sv
// Scoreboard bench for ysyx_20020207_lsu with a simple request/response bus model.
// Define LSU_MISALIGN_CHECK_EN to match a DUT built with misalignment trapping.
module tb_ysyx_20020207_lsu;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] alu_result, store_data;
    logic        mem_ren, mem_wen;
    logic [2:0]  funct3;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        misalign;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    always #5 clock = ~clock;

    ysyx_20020207_lsu dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .funct3        (funct3),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .misalign      (misalign),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_addr      (bus_addr),
        .bus_wen       (bus_wen),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          n_out = 0;
    int          n_exp = 0;
    int          n_req = 0;
    int          stall_cfg = 0;
    int          gap_cfg = 0;
    int          poke_req = 0;
    int          poke_ack = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [31:0] exp_addr = 32'h0;
    logic        exp_wen = 1'b0;
    logic [3:0]  exp_wstrb = 4'h0;
    logic [31:0] exp_wdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Bus model: holds ready low stall_cfg cycles, answers gap_cfg cycles after acceptance.
    initial begin
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = 32'h0;
        forever begin
            @(negedge clock);
            if (bus_req_valid === 1'b1) begin
                n_req++;
                for (int i = 0; i <= stall_cfg; i++) begin
                    if (i > 0) @(negedge clock);
                    check("req_valid_hold", 32'(bus_req_valid), 32'd1);
                    check("req_addr", bus_addr, exp_addr);
                    check("req_wen", 32'(bus_wen), 32'(exp_wen));
                    if (exp_wen) begin
                        check("req_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
                        check("req_wdata", bus_wdata, exp_wdata);
                    end
                    check("in_ready_busy", 32'(in_ready), 32'd0);
                end
                bus_req_ready = 1'b1;
                @(negedge clock);
                bus_req_ready = 1'b0;
                check("req_drop", 32'(bus_req_valid), 32'd0);
                repeat (gap_cfg) @(negedge clock);
                bus_rsp_valid = 1'b1;
                bus_rdata     = rdata_cfg;
                @(negedge clock);
                bus_rsp_valid = 1'b0;
                bus_rdata     = 32'h0;
            end else if (poke_req != poke_ack) begin
                poke_ack      = poke_req;
                bus_rsp_valid = 1'b1;
                bus_rdata     = 32'hFFFF_FFFF;
                @(negedge clock);
                bus_rsp_valid = 1'b0;
                bus_rdata     = 32'h0;
            end
        end
    end

    // Output monitor: every write-back handshake pops one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result, e.res);
                    check("misalign", 32'(misalign), 32'(e.mis));
                end
            end
        end
    end

    task automatic set_bus_exp(input logic [31:0] addr, input logic wen,
                               input logic [3:0] wstrb, input logic [31:0] wdata);
        exp_addr  = {addr[31:2], 2'b00};
        exp_wen   = wen;
        exp_wstrb = wstrb;
        exp_wdata = wdata;
    endtask

    task automatic issue(input string nm, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp_res,
                         input logic exp_mis, input int exp_lat, input int hold,
                         input logic [3:0] wstrb, input logic [31:0] wdata);
        exp_t e;
        int   lat;
        int   cnt;
        rdata_cfg = rdata;
        set_bus_exp(addr, wen, wstrb, wdata);
        e.res = exp_res;
        e.mis = exp_mis;
        sb_q.push_back(e);
        n_exp++;
        @(posedge clock); #1;
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        out_ready  = (hold == 0);
        alu_result = addr;
        store_data = sdata;
        mem_ren    = ren;
        mem_wen    = wen;
        funct3     = f3;
        in_valid   = 1'b1;
        @(posedge clock); #1;
        in_valid   = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        alu_result = 32'h5A5A_5A5B;
        store_data = 32'h1111_1111;
        funct3     = 3'b111;
        lat = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clock); #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clock); #1;
                check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({nm, "_hold_result"}, result, exp_res);
                check({nm, "_hold_busy"}, 32'(in_ready), 32'd0);
            end
            @(posedge clock); #1;
            out_ready = 1'b1;
        end
        cnt = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clock); #1;
            if (in_ready === 1'b1) begin
                cnt = k;
                break;
            end
        end
        check({nm, "_ready_back"}, 32'(cnt), (hold == 0) ? 32'd1 : 32'd2);
        check({nm, "_out_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int req0;
        int out0;
        int seen;
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        alu_result = 32'h0;
        store_data = 32'h0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        funct3     = 3'b000;
        out_ready  = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(bus_req_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        issue("add", 32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0000_1234, 1'b0, 1, 0, 4'h0, 32'h0);
        issue("add_hold", 32'hA5A5_0001, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'hA5A5_0001, 1'b0, 1, 3, 4'h0, 32'h0);
        issue("lb", 32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0, 3, 0, 4'h0, 32'h0);
        issue("lbu", 32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'b100, 32'h80FF_0000, 32'h0000_0080, 1'b0, 3, 0, 4'h0, 32'h0);
        issue("lh", 32'h8000_0002, 32'h0, 1'b1, 1'b0, 3'b001, 32'h80FF_0000, 32'hFFFF_80FF, 1'b0, 3, 0, 4'h0, 32'h0);
        issue("lhu", 32'h8000_0002, 32'h0, 1'b1, 1'b0, 3'b101, 32'h80FF_0000, 32'h0000_80FF, 1'b0, 3, 0, 4'h0, 32'h0);
        issue("lb_pos", 32'h8000_0001, 32'h0, 1'b1, 1'b0, 3'b000, 32'h0000_7F00, 32'h0000_007F, 1'b0, 3, 0, 4'h0, 32'h0);
        issue("lw", 32'h8000_0004, 32'h0, 1'b1, 1'b0, 3'b010, 32'h1234_5678, 32'h1234_5678, 1'b0, 3, 0, 4'h0, 32'h0);
        issue("sh", 32'h8000_0002, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b001, 32'h0, 32'h0, 1'b0, 3, 0, 4'b1100, 32'hBEEF_BEEF);
        issue("sb", 32'h8000_0001, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 1'b0, 3, 0, 4'b0010, 32'hA5A5_A5A5);
        gap_cfg = 1;
        issue("sw", 32'h8000_0008, 32'hCAFE_BABE, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0, 1'b0, 4, 0, 4'b1111, 32'hCAFE_BABE);

        stall_cfg = 5;
        gap_cfg   = 3;
        issue("lw_stall", 32'h8000_0010, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 11, 0, 4'h0, 32'h0);
        stall_cfg = 0;

        // Flush while waiting for the response: response drained, nothing written back.
        out0 = n_out;
        set_bus_exp(32'h8000_0020, 1'b0, 4'h0, 32'h0);
        rdata_cfg = 32'h7777_7777;
        @(posedge clock); #1;
        alu_result = 32'h8000_0020;
        mem_ren    = 1'b1;
        funct3     = 3'b010;
        in_valid   = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        mem_ren  = 1'b0;
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock); #1;
            if (bus_rsp_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("fw_rsp_seen", 32'(seen), 32'd1);
        check("fw_busy_at_rsp", 32'(in_ready), 32'd0);
        @(negedge clock); #1;
        check("fw_ready_after", 32'(in_ready), 32'd1);
        check("fw_no_out", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clock);
        check("fw_no_delivery", 32'(n_out), 32'(out0));
        gap_cfg = 0;

        // Flush while the result is waiting in DONE.
        @(posedge clock); #1;
        out_ready  = 1'b0;
        alu_result = 32'h0000_BEEF;
        in_valid   = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock); #1;
        check("fd_valid", 32'(out_valid), 32'd1);
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock); #1;
        check("fd_out_drop", 32'(out_valid), 32'd0);
        check("fd_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;

        // Flush together with in_valid in IDLE: input refused.
        req0 = n_req;
        @(posedge clock); #1;
        alu_result = 32'h8000_0040;
        mem_ren    = 1'b1;
        funct3     = 3'b010;
        in_valid   = 1'b1;
        flush      = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        mem_ren  = 1'b0;
        flush    = 1'b0;
        @(negedge clock); #1;
        check("fi_ready", 32'(in_ready), 32'd1);
        check("fi_no_out", 32'(out_valid), 32'd0);
        check("fi_no_req", 32'(bus_req_valid), 32'd0);

        // Stray response while idle is ignored.
        @(posedge clock); #1;
        poke_req++;
        repeat (3) @(negedge clock);
        #1;
        check("stray_no_out", 32'(out_valid), 32'd0);
        check("stray_ready", 32'(in_ready), 32'd1);
        check("stray_no_req", 32'(n_req), 32'(req0));

        req0 = n_req;
`ifdef LSU_MISALIGN_CHECK_EN
        issue("lw_mis", 32'h8000_0002, 32'h0, 1'b1, 1'b0, 3'b010, 32'hCAFE_F00D, 32'h8000_0002, 1'b1, 1, 0, 4'h0, 32'h0);
        check("lw_mis_no_req", 32'(n_req), 32'(req0));
        issue("sh_mis", 32'h8000_0003, 32'h1234_5678, 1'b0, 1'b1, 3'b001, 32'h0, 32'h8000_0003, 1'b1, 1, 0, 4'h0, 32'h0);
        check("sh_mis_no_req", 32'(n_req), 32'(req0));
`else
        issue("lw_mis", 32'h8000_0002, 32'h0, 1'b1, 1'b0, 3'b010, 32'hCAFE_F00D, 32'h0000_CAFE, 1'b0, 3, 0, 4'h0, 32'h0);
        check("lw_mis_req", 32'(n_req), 32'(req0 + 1));
`endif
        issue("add_last", 32'h0000_0042, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0000_0042, 1'b0, 1, 0, 4'h0, 32'h0);

        repeat (2) @(negedge clock);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("out_count", 32'(n_out), 32'(n_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_20020207_lsu.md
# ysyx_20020207_lsu

Load/store unit sitting directly downstream of the ALU stage in the ysyx_20020207 core. It accepts the ALU result as a byte address or as a pass-through value, runs one memory transaction per instruction over a simple request/response bus, and aligns and extends load data. The result goes to the write-back stage over a valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, since lane logic assumes 4 bytes.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  kill the current instruction (branch or jump redirect).
- in_valid  in  1  ALU result valid.
- in_ready  out  1  LSU can accept.
- alu_result  in  32  address for memory ops, else the value to forward.
- store_data  in  32  rs2 value.
- mem_ren  in  1  load.
- mem_wen  in  1  store; mem_ren and mem_wen are never both 1.
- funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW.
- out_valid  out  1  result valid to write-back.
- out_ready  in  1  write-back accepts.
- result  out  32  load data or forwarded alu_result.
- misalign  out  1  valid with out_valid; only when LSU_MISALIGN_CHECK_EN is defined, else tied 0.
- bus_req_valid  out  1; bus_req_ready  in  1.
- bus_addr  out  32  word-aligned (addr & ~3).
- bus_wen  out  1.
- bus_wdata  out  32.
- bus_wstrb  out  4.
- bus_rsp_valid  in  1.
- bus_rdata  in  32.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture all inputs.
  - Memory op → REQ.
  - Otherwise → DONE with result=alu_result.
- REQ:
  - bus_req_valid=1 with stable addr/wen/wdata/wstrb until bus_req_ready.
  - Then → WAIT.
- WAIT:
  - On bus_rsp_valid → DONE.
  - Loads latch the extracted data.
  - Stores set result=0.
- DONE:
  - out_valid=1; hold result until out_ready.
  - Then → IDLE.
- Store lanes, with o = addr[1:0]:
  - SB: wstrb=4'b0001<<o, wdata={4{byte}}.
  - SH: wstrb=4'b0011<<o, wdata={2{half}}.
  - SW: wstrb=4'b1111, wdata as given.
- Load extract:
  - Shift bus_rdata right by 8·o.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word.
- Unaligned within word:
  - SH with o=3 and LH/LHU with o=3 are misaligned.
  - Any LW/SW with o≠0 is misaligned.
- Flush:
  - IDLE or DONE: return to IDLE; out_valid drops the next cycle; nothing is delivered.
  - REQ or WAIT: the bus transaction completes (the bus has no abort); a kill flag is set, and on the response the FSM goes to IDLE instead of DONE.
  - flush with in_valid in IDLE: the input is not accepted.
- bus_rsp_valid outside WAIT is ignored.

## Timing
- Reset values:
  - State IDLE, in_ready=1, out_valid=0, bus_req_valid=0.
  - result=0, misalign=0, kill=0.
  - Reset mid-transaction abandons it; the bus owner must also be reset.
- Pass-through latency: accept at cycle N, out_valid at N+1.
- Memory latency: bus_req_valid at N+1. With ready at N+1 and rsp at N+2, out_valid is at N+3.
- The bus guarantees rsp_valid no earlier than the cycle after req acceptance.
- in_ready is 0 from the accept cycle+1 until the cycle after the out handshake, so there is no back-to-back overlap.
- Outputs are registered; no combinational path from out_ready or bus_* to in_ready.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - A misaligned access issues no bus request and goes IDLE→DONE directly.
  - misalign=1, result=alu_result (the bad address).
- Not defined:
  - Misalignment is not detected and misalign is constant 0.
  - The access proceeds with the wstrb and shift computed from o, truncated to the word.

## Structure
- Package ysyx_20020207_lsu_pkg holds:
  - funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - FSM state enum.
  - Lane width constants.
- Sub-module ysyx_20020207_lsu_align, combinational:
  - Inputs: funct3, offset, store_data, bus_rdata.
  - Outputs: wstrb, wdata, load_data, misaligned.

## Test plan
- ADD pass-through: alu_result=0x1234, no mem op → out_valid one cycle later, result=0x1234.
- LB: addr 0x80000003, rdata 0x80FF_0000 → result 0xFFFFFF80, bus_addr 0x80000000. LBU on the same data → 0x00000080.
- SH: addr 0x80000002, store_data 0xDEADBEEF → wstrb 4'b1100, wdata 0xBEEFBEEF, result 0.
- Bus stall: bus_req_ready low 5 cycles, rsp after 3 more → request fields stable, out_valid once, in_ready low throughout.
- Flush in WAIT: LW pending, flush pulse → rsp is consumed, no out_valid, in_ready high the cycle after the rsp.
- With LSU_MISALIGN_CHECK_EN, LW at 0x80000002 → no bus_req_valid, misalign=1, result 0x80000002. Without the macro, the bus request is issued.
